// File: rtl/vdf_iteration_sequencer_if.sv
// rtl/vdf_iteration_sequencer_if.sv - command, status and MSU handshake bundle for the VDF sequencer
interface vdf_iteration_sequencer_if #(
    parameter int MOD_LEN  = 1024,
    parameter int WORD_LEN = 16,
    parameter int ITER_W   = 64
);
    localparam int NONRED       = MOD_LEN / WORD_LEN;
    localparam int NUM_ELEMENTS = NONRED + 2;
    localparam int SQ_OUT_BITS  = NUM_ELEMENTS * WORD_LEN * 2;

    logic                   cmd_start;
    logic                   cmd_abort;
    logic [MOD_LEN-1:0]     x_in;
    logic [ITER_W-1:0]      iter_count;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [ITER_W-1:0]      iters_left;
    logic [MOD_LEN-1:0]     result;
    logic                   msu_start;
    logic [MOD_LEN-1:0]     msu_sq_in;
    logic [SQ_OUT_BITS-1:0] msu_sq_out;
    logic                   msu_valid;

    modport slave (
        input  cmd_start, cmd_abort, x_in, iter_count, msu_sq_out, msu_valid,
        output busy, done, error, iters_left, result, msu_start, msu_sq_in
    );

    modport master (
        output cmd_start, cmd_abort, x_in, iter_count, msu_sq_out, msu_valid,
        input  busy, done, error, iters_left, result, msu_start, msu_sq_in
    );
endinterface

// File: rtl/vdf_iteration_sequencer.sv
// rtl/vdf_iteration_sequencer.sv - closes the VDF squaring loop around the modular square unit
module vdf_iteration_sequencer #(
    parameter int MOD_LEN        = 1024,
    parameter int WORD_LEN       = 16,
    parameter int ITER_W         = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    vdf_iteration_sequencer_if.slave    bus
);
    localparam int NONRED       = MOD_LEN / WORD_LEN;
    localparam int NUM_ELEMENTS = NONRED + 2;
    localparam int CW           = WORD_LEN + 1;          // significant bits per MSU coefficient
    localparam int SHIFT_W      = NUM_ELEMENTS * CW;
    localparam int TW           = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int IDX_W        = $clog2(NUM_ELEMENTS);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NORM, S_DONE, S_ERR} state_t;

    state_t              state_q, state_d;
    logic [MOD_LEN-1:0]  result_q, result_d;
    logic [ITER_W-1:0]   iters_q, iters_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [SHIFT_W-1:0]  coef_q, coef_d;
    logic [WORD_LEN+1:0] carry_q, carry_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [MOD_LEN-1:0]  next_q, next_d;
    logic                red_q, red_d;

    logic [WORD_LEN+1:0] sum;
    logic [TW-1:0]       timer_inc;
    logic                final_nz;
    logic                unused_hi;

    // Serial normaliser datapath: current coefficient plus incoming carry, full 18-bit width.
    assign sum       = {1'b0, coef_q[CW-1:0]} + carry_q;
    // The timeout compares the post-increment count so ERR lands TIMEOUT_CYCLES after msu_start.
    assign timer_inc = timer_q + 1'b1;
    assign final_nz  = red_q | (|sum[WORD_LEN-1:0]) | (|sum[WORD_LEN+1:WORD_LEN]);

    // Fold the ignored upper bits of each 32-bit MSU lane so they are visibly consumed.
    always_comb begin
        unused_hi = 1'b0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            unused_hi = unused_hi ^ (^bus.msu_sq_out[j*2*WORD_LEN+CW +: 2*WORD_LEN-CW]);
        end
    end

    // State and datapath registers; async reset returns everything to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            iters_q  <= '0;
            timer_q  <= '0;
            coef_q   <= '0;
            carry_q  <= '0;
            idx_q    <= '0;
            next_q   <= '0;
            red_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            iters_q  <= iters_d;
            timer_q  <= timer_d;
            coef_q   <= coef_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            next_q   <= next_d;
            red_q    <= red_d;
        end
    end

    // Next-state and datapath update; abort overrides every other event.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        iters_d  = iters_q;
        timer_d  = timer_q;
        coef_d   = coef_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        next_d   = next_q;
        red_d    = red_q;
        if (bus.cmd_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.cmd_start) begin
                        result_d = bus.x_in;
                        iters_d  = bus.iter_count;
                        state_d  = (bus.iter_count == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    timer_d = timer_inc;
                    if (bus.msu_valid) begin
                        for (int j = 0; j < NUM_ELEMENTS; j++) begin
                            coef_d[j*CW +: CW] = bus.msu_sq_out[j*2*WORD_LEN +: CW];
                        end
                        carry_d = '0;
                        idx_d   = '0;
                        red_d   = 1'b0;
                        state_d = S_NORM;
                    end else if (timer_inc == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_ERR;
                    end
                end
                S_NORM: begin
                    coef_d  = coef_q >> CW;
                    carry_d = sum >> WORD_LEN;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q < IDX_W'(NONRED)) begin
                        next_d = {sum[WORD_LEN-1:0], next_q[MOD_LEN-1:WORD_LEN]};
                    end else begin
                        red_d = red_q | (|sum[WORD_LEN-1:0]);
                    end
                    if (idx_q == IDX_W'(NUM_ELEMENTS - 1)) begin
                        if (final_nz) begin
                            state_d = S_ERR;
                        end else begin
                            result_d = next_q;
                            iters_d  = iters_q - 1'b1;
                            state_d  = (iters_q == ITER_W'(1)) ? S_DONE : S_ISSUE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.busy       = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_NORM);
    assign bus.done       = (state_q == S_DONE);
    assign bus.error      = (state_q == S_ERR);
    assign bus.msu_start  = (state_q == S_ISSUE);
    assign bus.result     = result_q;
    assign bus.msu_sq_in  = result_q;
    assign bus.iters_left = iters_q;
endmodule

// File: tb/tb_vdf_iteration_sequencer.sv
// tb/tb_vdf_iteration_sequencer.sv - scoreboard bench for vdf_iteration_sequencer
module tb_vdf_iteration_sequencer;
    localparam int MOD_LEN  = 1024;
    localparam int WORD_LEN = 16;
    localparam int ITER_W   = 64;
    localparam int TIMEOUT  = 4096;
    localparam int NONRED   = MOD_LEN / WORD_LEN;
    localparam int NUM_EL   = NONRED + 2;
    localparam int SQB      = NUM_EL * 32;

    typedef logic [MOD_LEN-1:0]    val_t;
    typedef logic [SQB-1:0]        vec_t;
    typedef logic [MOD_LEN+39:0]   wide_t;
    typedef struct {
        bit                is_err;
        val_t              result;
        logic [ITER_W-1:0] iters;
        int                starts;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vdf_iteration_sequencer_if #(.MOD_LEN(MOD_LEN), .WORD_LEN(WORD_LEN), .ITER_W(ITER_W)) ifc();

    vdf_iteration_sequencer #(
        .MOD_LEN(MOD_LEN), .WORD_LEN(WORD_LEN), .ITER_W(ITER_W), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input val_t act, input val_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference helpers: plain integer arithmetic on the coefficient values.
    function automatic wide_t ref_value(input vec_t v);
        wide_t s = '0;
        for (int j = 0; j < NUM_EL; j++) s = s + (wide_t'(v[j*32 +: 17]) << (16*j));
        return s;
    endfunction

    function automatic val_t sqmod(input val_t v, input val_t n);
        logic [2*MOD_LEN-1:0] p;
        p = {{MOD_LEN{1'b0}}, v} * {{MOD_LEN{1'b0}}, v};
        p = p % {{MOD_LEN{1'b0}}, n};
        return p[MOD_LEN-1:0];
    endfunction

    function automatic val_t rand_wide();
        val_t r;
        for (int j = 0; j < MOD_LEN/32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    // Random redundant encoding of v: borrows move 0x10000 down a word, junk fills bits 31:17.
    function automatic vec_t redund(input val_t v);
        vec_t r = '0;
        int c[NUM_EL];
        logic [16:0] cj;
        for (int j = 0; j < NUM_EL; j++) c[j] = (j < NONRED) ? int'(v[j*16 +: 16]) : 0;
        for (int j = 0; j < NONRED-1; j++) begin
            if (c[j+1] > 0 && $urandom_range(1, 0) == 1) begin
                c[j]   = c[j] + 65536;
                c[j+1] = c[j+1] - 1;
            end
        end
        for (int j = 0; j < NUM_EL; j++) begin
            cj = 17'(c[j]);
            r[j*32 +: 17]    = cj;
            r[j*32+17 +: 15] = 15'($urandom);
        end
        return r;
    endfunction

    // MSU model state
    int   resp_mode = 0;          // 0: square mod N, 1: silent, 2: scripted vectors
    val_t mod_n = val_t'(97);
    int   lat_min = 2, lat_max = 10;
    vec_t script_q[$];
    int   starts_cnt = 0, start_cyc = 0, valid_cyc = 0, rst_gen = 0, gen_cap = 0;
    bit   pend = 0;
    int   cnt = 0;
    vec_t resp;
    val_t sq_cap;

    initial begin
        ifc.msu_valid  = 1'b0;
        ifc.msu_sq_out = '0;
        forever begin
            @(posedge clk); #1;
            ifc.msu_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend = 0;
                    ifc.msu_valid  = 1'b1;
                    ifc.msu_sq_out = resp;
                    valid_cyc      = cyc;
                    if (gen_cap == rst_gen) check("sq_in_stable", ifc.msu_sq_in, sq_cap);
                end
            end
            if (ifc.msu_start === 1'b1) begin
                starts_cnt++;
                start_cyc = cyc;
                sq_cap    = ifc.msu_sq_in;
                gen_cap   = rst_gen;
                if (resp_mode == 0) begin
                    resp = redund(sqmod(ifc.msu_sq_in, mod_n));
                    pend = 1;
                    cnt  = $urandom_range(lat_max, lat_min);
                end else if (resp_mode == 2 && script_q.size() > 0) begin
                    resp = script_q.pop_front();
                    pend = 1;
                    cnt  = $urandom_range(lat_max, lat_min);
                end
            end
        end
    end

    // Monitor: each rising done/error consumes one expectation.
    exp_t sb_q[$];
    bit   prev_fin = 0;
    int   fin_evt = 0, done_cyc = 0;
    initial begin
        exp_t e;
        bit fin;
        forever begin
            @(negedge clk);
            fin = (ifc.done === 1'b1) || (ifc.error === 1'b1);
            if (fin && !prev_fin) begin
                done_cyc = cyc;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_empty: got completion with no expectation queued");
                end else begin
                    e = sb_q.pop_front();
                    check("sb_error", val_t'(ifc.error), val_t'(e.is_err));
                    check("sb_done", val_t'(ifc.done), val_t'(!e.is_err));
                    check("sb_result", ifc.result, e.result);
                    check("sb_iters_left", val_t'(ifc.iters_left), val_t'(e.iters));
                    check("sb_starts", val_t'(starts_cnt), val_t'(e.starts));
                end
                fin_evt++;
            end
            prev_fin = fin;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int cmd_cyc = 0;

    task automatic push_exp(input bit is_err, input val_t r, input logic [ITER_W-1:0] it, input int st);
        exp_t e;
        e.is_err = is_err; e.result = r; e.iters = it; e.starts = st;
        sb_q.push_back(e);
    endtask

    task automatic pulse_abort();
        @(posedge clk); #1 ifc.cmd_abort = 1'b1;
        @(posedge clk); #1 ifc.cmd_abort = 1'b0;
    endtask

    task automatic start_run(input val_t x, input logic [ITER_W-1:0] n);
        ifc.cmd_start  = 1'b1;
        ifc.x_in       = x;
        ifc.iter_count = n;
        starts_cnt     = 0;
        cmd_cyc        = cyc;
        @(posedge clk); #1 ifc.cmd_start = 1'b0;
    endtask

    task automatic wait_fin(input int start_evt, input int budget, input string name);
        int k = 0;
        while (fin_evt == start_evt && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (fin_evt == start_evt) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: no completion within %0d cycles", name, budget);
        end
    endtask

    task automatic square_run(input val_t x, input logic [ITER_W-1:0] n, input bit poke);
        val_t v = x;
        int ev;
        for (int i = 0; i < int'(n); i++) v = sqmod(v, mod_n);
        pulse_abort();
        sb_q.delete();
        push_exp(1'b0, v, '0, int'(n));
        ev = fin_evt;
        start_run(x, n);
        if (poke) begin
            repeat (10) @(posedge clk);
            #1 ifc.cmd_start = 1'b1; ifc.x_in = rand_wide(); ifc.iter_count = 64'd7;
            @(posedge clk); #1 ifc.cmd_start = 1'b0;
        end
        wait_fin(ev, 2000, "square_run");
    endtask

    initial begin
        int   ev;
        bit   bad;
        vec_t va, vb;
        val_t x0;
        ifc.cmd_start = 1'b0; ifc.cmd_abort = 1'b0; ifc.x_in = '0; ifc.iter_count = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", val_t'(ifc.busy), '0);
        check("rst_done", val_t'(ifc.done), '0);
        check("rst_error", val_t'(ifc.error), '0);
        check("rst_result", ifc.result, '0);
        check("rst_iters", val_t'(ifc.iters_left), '0);
        check("rst_msu_start", val_t'(ifc.msu_start), '0);
        #2 reset = 1'b0;

        // T1: x=3, single squaring returning c0=9
        resp_mode = 2; lat_min = 3; lat_max = 3;
        va = '0; va[16:0] = 17'd9;
        script_q.push_back(va);
        pulse_abort(); sb_q.delete();
        push_exp(1'b0, val_t'(9), '0, 1);
        ev = fin_evt;
        start_run(val_t'(3), 64'd1);
        wait_fin(ev, 500, "t1");
        check("t1_latency", val_t'(done_cyc - valid_cyc), val_t'(NUM_EL + 1));

        // T2: carry chain
        va = '0; va[16:0] = 17'h1FFFF; va[48:32] = 17'h00001; va[31:17] = 15'h7ABC;
        script_q.push_back(va);
        pulse_abort(); sb_q.delete();
        push_exp(1'b0, val_t'(ref_value(va)), '0, 1);
        ev = fin_evt;
        start_run(rand_wide(), 64'd1);
        wait_fin(ev, 500, "t2");
        check("t2_result", ifc.result, val_t'(32'h0002FFFF));

        // T3: overflow into a redundant word on the second squaring
        x0 = rand_wide();
        va = redund(rand_wide());
        vb = '0; vb[NONRED*32 +: 17] = 17'd1;
        script_q.push_back(va);
        script_q.push_back(vb);
        pulse_abort(); sb_q.delete();
        push_exp(1'b1, val_t'(ref_value(va)), 64'd1, 2);
        ev = fin_evt;
        start_run(x0, 64'd2);
        wait_fin(ev, 800, "t3");

        // T4: zero iterations
        pulse_abort(); sb_q.delete();
        push_exp(1'b0, val_t'(16'h1234), '0, 0);
        ev = fin_evt;
        start_run(val_t'(16'h1234), 64'd0);
        wait_fin(ev, 50, "t4");
        check("t4_latency", val_t'(done_cyc - cmd_cyc), val_t'(1));

        // T5: MSU never answers
        resp_mode = 1;
        x0 = rand_wide();
        pulse_abort(); sb_q.delete();
        push_exp(1'b1, x0, 64'd3, 1);
        ev = fin_evt;
        start_run(x0, 64'd3);
        wait_fin(ev, TIMEOUT + 100, "t5");
        check("t5_timeout_cycles", val_t'(done_cyc - start_cyc), val_t'(TIMEOUT));
        pulse_abort();
        @(negedge clk);
        check("t5_abort_busy", val_t'(ifc.busy), '0);
        check("t5_abort_error", val_t'(ifc.error), '0);
        check("t5_abort_result", ifc.result, x0);

        // Randomised squaring runs, some with an ignored cmd_start mid-run
        resp_mode = 0;
        for (int r = 0; r < 6; r++) begin
            mod_n   = val_t'($urandom_range(32'h00FFFFFF, 32'h00000011) | 32'h1);
            lat_min = 1; lat_max = $urandom_range(12, 1);
            square_run(rand_wide(), ITER_W'($urandom_range(4, 1)), r[0]);
        end

        // T6: reset in the WAIT of the third squaring, stale valid arrives in IDLE
        mod_n = val_t'(32'h0001FFF1); lat_min = 30; lat_max = 30;
        x0 = rand_wide();
        pulse_abort(); sb_q.delete();
        push_exp(1'b0, '0, '0, 5);
        ev = fin_evt;
        start_run(x0, 64'd5);
        for (int k = 0; k < 1000 && starts_cnt < 3; k++) @(negedge clk);
        check("t6_reached_iter3", val_t'(starts_cnt), val_t'(3));
        repeat (10) @(negedge clk);
        #2 reset = 1'b1; rst_gen++; sb_q.delete();
        #1;
        check("t6_rst_busy", val_t'(ifc.busy), '0);
        check("t6_rst_result", ifc.result, '0);
        check("t6_rst_iters", val_t'(ifc.iters_left), '0);
        check("t6_rst_done_err", val_t'({ifc.done, ifc.error, ifc.msu_start}), '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.error !== 1'b0 || ifc.result !== '0) bad = 1;
        end
        check("t6_stale_delivered", val_t'(pend), '0);
        check("t6_stale_ignored", val_t'(bad), '0);
        lat_min = 1; lat_max = 8;
        square_run(rand_wide(), 64'd5, 1'b0);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
